// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared constants and types for the IF-stage prefetch front end.
// Holds the NOP encoding, fetch FSM state codes and the queue entry layout.
package fetch_prefetch_unit_pkg;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  localparam logic [1:0] FS_IDLE      = 2'd0;
  localparam logic [1:0] FS_WAIT      = 2'd1;
  localparam logic [1:0] FS_WAIT_DROP = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_prefetch_unit_if.sv
// Bundle of the instruction-memory, redirect, IF/ID and perf-counter signals of the fetch unit.
// master = fetch unit side, slave = environment (memory, EX, decode) side.
interface fetch_prefetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        id_ready;
  logic [31:0] perf_starve_cnt;
  logic [31:0] perf_flush_cnt;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4,
           perf_starve_cnt, perf_flush_cnt,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4,
           perf_starve_cnt, perf_flush_cnt,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO of {pc, instr} entries with binary wrap pointers.
// Flush clears both pointers; storage itself is never reset.
module fetch_queue
  import fetch_prefetch_unit_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           flush,
  input  fetch_entry_t                   wdata,
  output fetch_entry_t                   rdata,
  output logic [$clog2(QUEUE_DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(QUEUE_DEPTH);

  fetch_entry_t mem [QUEUE_DEPTH];
  logic [AW:0]  wptr_q, rptr_q;

  // The extra MSB distinguishes full from empty when the index bits match.
  assign count = wptr_q - rptr_q;
  assign rdata = mem[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush && !reset) mem[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// IF-stage front end: single-outstanding fetch FSM feeding a prefetch queue toward IF/ID.
// Optional perf counters are built only when FETCH_PERF_CNT_EN is defined.
module fetch_prefetch_unit
  import fetch_prefetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  fetch_prefetch_unit_if.master  bus
);
  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;

  logic [1:0]   state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  req_pc_q;
  logic [CW-1:0] count;
  logic         q_full, q_push, q_pop, grant;
  fetch_entry_t head, push_entry;
  logic         unused_redirect_lsb;

  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

  assign q_full        = (count == CW'(QUEUE_DEPTH));
  assign bus.imem_req  = (state_q == FS_IDLE) && !q_full && !bus.redirect_valid;
  assign bus.imem_addr = fetch_pc_q;
  assign grant         = bus.imem_req && bus.imem_gnt;

  // Redirect overrides both push and pop; the queue is flushed instead.
  assign q_push     = (state_q == FS_WAIT) && bus.imem_rvalid && !bus.redirect_valid;
  assign q_pop      = bus.if_valid && bus.id_ready && !bus.redirect_valid;
  assign push_entry = '{pc: req_pc_q, instr: bus.imem_rdata};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      FS_IDLE: begin
        if (grant) begin
          state_d    = FS_WAIT;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
      end
      FS_WAIT: begin
        if (bus.imem_rvalid)         state_d = FS_IDLE;
        else if (bus.redirect_valid) state_d = FS_WAIT_DROP;
      end
      FS_WAIT_DROP: begin
        if (bus.imem_rvalid) state_d = FS_IDLE;
      end
      default: state_d = FS_IDLE;
    endcase
    if (bus.redirect_valid) fetch_pc_d = word_align(bus.redirect_pc);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FS_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      if (grant) req_pc_q <= fetch_pc_q;
    end
  end

  fetch_queue #(
    .QUEUE_DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (q_push),
    .pop   (q_pop),
    .flush (bus.redirect_valid),
    .wdata (push_entry),
    .rdata (head),
    .count (count)
  );

  // An empty queue presents a NOP at pc 0 so decode never sees stale storage.
  assign bus.if_valid    = (count != '0);
  assign bus.if_instr    = bus.if_valid ? head.instr : RV_NOP;
  assign bus.if_pc       = bus.if_valid ? head.pc : 32'h0;
  assign bus.if_pc_plus4 = bus.if_pc + 32'd4;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] starve_q, flush_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
      flush_q  <= '0;
    end else begin
      if (bus.id_ready && !bus.if_valid) starve_q <= starve_q + 32'd1;
      if (bus.redirect_valid)            flush_q  <= flush_q + 32'd1;
    end
  end

  assign bus.perf_starve_cnt = starve_q;
  assign bus.perf_flush_cnt  = flush_q;
`else
  assign bus.perf_starve_cnt = 32'h0;
  assign bus.perf_flush_cnt  = 32'h0;
`endif

endmodule
